// File: rtl/l4_pkg.sv
// Shared lab 4 fetch definitions: default geometry and the fetch FSM state encoding.
package l4_pkg;

  localparam int ADDR_W   = 8;
  localparam int INSTR_W  = 16;
  localparam int PROG_LEN = 21;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/l4_fetch.sv
// l4_fetch: owns the pc, addresses instruction memory and registers instructions for decode (mem read to instr_valid: 1 cycle).
// Backpressure: instr/instr_pc/instr_valid/count all hold while instr_valid && !instr_ready; redirect costs one bubble.
module l4_fetch #(
  parameter int ADDR_W   = l4_pkg::ADDR_W,
  parameter int INSTR_W  = l4_pkg::INSTR_W,
  parameter int PROG_LEN = l4_pkg::PROG_LEN
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [ADDR_W-1:0]  count,
  input  logic [INSTR_W-1:0] mem_data,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               halt
);

  import l4_pkg::*;

  // One extra pc bit so a full 2^ADDR_W image ends at PROG_LEN without wrapping to 0.
  localparam logic [ADDR_W:0] LEN = PROG_LEN[ADDR_W:0];

  fetch_state_t       state, state_n;
  logic [ADDR_W:0]    pc, pc_n;
  logic [INSTR_W-1:0] instr_n;
  logic [ADDR_W-1:0]  instr_pc_n;
  logic               valid_n;
  logic               slot_free;

  assign slot_free = !instr_valid || instr_ready;
  assign count     = pc[ADDR_W-1:0];
  assign halt      = (state == HALTED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      instr       <= instr_n;
      instr_pc    <= instr_pc_n;
      instr_valid <= valid_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    instr_n    = instr;
    instr_pc_n = instr_pc;
    valid_n    = instr_valid;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = FETCH;
          pc_n    = '0;
        end
      end
      FETCH: begin
        // Redirect flushes the slot; a concurrent handshake still completes on the decode side.
        if (redirect) begin
          pc_n    = {1'b0, redirect_pc};
          valid_n = 1'b0;
        end else if (slot_free && pc < LEN) begin
          instr_n    = mem_data;
          instr_pc_n = count;
          valid_n    = 1'b1;
          pc_n       = pc + {{ADDR_W{1'b0}}, 1'b1};
        end else if (slot_free) begin
          // Also reached for out-of-range redirect targets; park count at the image end.
          valid_n = 1'b0;
          pc_n    = LEN;
          state_n = HALTED;
        end
      end
      HALTED: begin
        valid_n = 1'b0;
        if (redirect) begin
          state_n = FETCH;
          pc_n    = {1'b0, redirect_pc};
        end
      end
      default: begin
        state_n = IDLE;
        pc_n    = '0;
        valid_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_l4_fetch.sv
// Scoreboard bench for l4_fetch: directed stimulus queues expected pcs, a negedge monitor checks every transfer.
module tb_l4_fetch;

  localparam int AW = 8;
  localparam int IW = 16;
  localparam int PL = 21;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] count;
  logic [IW-1:0] mem_data;
  logic [IW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          halt;

  int n_checks = 0;
  int n_fail   = 0;
  int n_xfer   = 0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] exp_pc;

  always #5 clk = ~clk;

  // Memory image: word at address a is {a, ~a}, e.g. mem[5] = 16'h05FA.
  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    return {a, ~a};
  endfunction

  assign mem_data = mem_word(count);

  l4_fetch #(.ADDR_W(AW), .INSTR_W(IW), .PROG_LEN(PL)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .count       (count),
    .mem_data    (mem_data),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (halt) check("valid_while_halt", {31'd0, instr_valid}, 32'd0);
      if (instr_valid && instr_ready) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_xfer: got pc %0h, expected no transfer", instr_pc);
        end else begin
          exp_pc = exp_q.pop_front();
          check("xfer_pc", {24'd0, instr_pc}, {24'd0, exp_pc});
          check("xfer_instr", {16'd0, instr}, {16'd0, mem_word(exp_pc)});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) exp_q.push_back(AW'(i));
  endtask

  task automatic wait_halt(input string name);
    for (int i = 0; i < 60 && !halt; i++) tick();
    check(name, {31'd0, halt}, 32'd1);
  endtask

  task automatic wait_pc(input logic [AW-1:0] p, input string name);
    for (int i = 0; i < 60 && !(instr_valid && instr_pc == p); i++) tick();
    check(name, {31'd0, instr_valid && instr_pc == p}, 32'd1);
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;

    // Reset state
    #12;
    check("rst_count", {24'd0, count}, 32'd0);
    check("rst_instr", {16'd0, instr}, 32'd0);
    check("rst_instr_pc", {24'd0, instr_pc}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_halt", {31'd0, halt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Start and full program
    tick();
    start = 1'b1;
    instr_ready = 1'b1;
    push_range(0, PL - 1);
    tick();
    start = 1'b0;
    check("c1_count", {24'd0, count}, 32'd0);
    check("c1_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    check("c2_count", {24'd0, count}, 32'd1);
    check("c2_valid", {31'd0, instr_valid}, 32'd1);
    check("c2_instr_pc", {24'd0, instr_pc}, 32'd0);
    check("c2_instr", {16'd0, instr}, 32'h00FF);
    wait_halt("halt_full");
    check("halt_count", {24'd0, count}, 32'd21);
    check("full_xfers", n_xfer, 32'd21);
    check("full_q_empty", exp_q.size(), 32'd0);
    repeat (3) tick();
    check("no_xfer_after_halt", n_xfer, 32'd21);

    // Backpressure at pc 5
    redirect = 1'b1;
    redirect_pc = 8'd0;
    push_range(0, 7);
    tick();
    redirect = 1'b0;
    check("rehalt_clear", {31'd0, halt}, 32'd0);
    check("rehalt_count", {24'd0, count}, 32'd0);
    wait_pc(8'd5, "reach_pc5");
    instr_ready = 1'b0;
    repeat (3) begin
      tick();
      check("stall_instr", {16'd0, instr}, 32'h05FA);
      check("stall_pc", {24'd0, instr_pc}, 32'd5);
      check("stall_valid", {31'd0, instr_valid}, 32'd1);
      check("stall_count", {24'd0, count}, 32'd6);
    end
    instr_ready = 1'b1;

    // Redirect with pc 7 completing its transfer
    wait_pc(8'd7, "reach_pc7");
    redirect = 1'b1;
    redirect_pc = 8'd2;
    push_range(2, PL - 1);
    tick();
    redirect = 1'b0;
    check("redir_bubble", {31'd0, instr_valid}, 32'd0);
    check("redir_count", {24'd0, count}, 32'd2);
    tick();
    check("redir_valid", {31'd0, instr_valid}, 32'd1);
    check("redir_pc", {24'd0, instr_pc}, 32'd2);
    check("redir_instr", {16'd0, instr}, 32'h02FD);
    wait_halt("halt_after_redir");
    check("redir_q_empty", exp_q.size(), 32'd0);

    // Redirect out of HALTED to 18
    redirect = 1'b1;
    redirect_pc = 8'd18;
    push_range(18, PL - 1);
    tick();
    redirect = 1'b0;
    check("h18_halt", {31'd0, halt}, 32'd0);
    check("h18_count", {24'd0, count}, 32'd18);
    wait_halt("halt_after_18");
    check("h18_q_empty", exp_q.size(), 32'd0);
    check("h18_count_end", {24'd0, count}, 32'd21);

    // Out-of-range redirect from FETCH, flushing a stalled pc 10
    instr_ready = 1'b0;
    redirect = 1'b1;
    redirect_pc = 8'd10;
    tick();
    redirect = 1'b0;
    tick();
    check("pc10_valid", {31'd0, instr_valid}, 32'd1);
    check("pc10_pc", {24'd0, instr_pc}, 32'd10);
    redirect = 1'b1;
    redirect_pc = 8'd25;
    tick();
    redirect = 1'b0;
    check("oor_valid", {31'd0, instr_valid}, 32'd0);
    check("oor_count", {24'd0, count}, 32'd25);
    check("oor_not_halt", {31'd0, halt}, 32'd0);
    tick();
    check("oor_halt", {31'd0, halt}, 32'd1);
    check("oor_valid2", {31'd0, instr_valid}, 32'd0);
    check("oor_count_end", {24'd0, count}, 32'd21);

    // Async reset in the middle of a stall
    redirect = 1'b1;
    redirect_pc = 8'd3;
    tick();
    redirect = 1'b0;
    tick();
    check("pre_rst_valid", {31'd0, instr_valid}, 32'd1);
    check("pre_rst_pc", {24'd0, instr_pc}, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, instr_valid}, 32'd0);
    check("arst_halt", {31'd0, halt}, 32'd0);
    check("arst_count", {24'd0, count}, 32'd0);
    check("arst_instr", {16'd0, instr}, 32'd0);
    check("arst_instr_pc", {24'd0, instr_pc}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    redirect = 1'b1;
    redirect_pc = 8'd9;
    tick();
    redirect = 1'b0;
    tick();
    check("idle_halt", {31'd0, halt}, 32'd0);
    check("idle_valid", {31'd0, instr_valid}, 32'd0);
    check("idle_count", {24'd0, count}, 32'd0);

    // Restart from IDLE runs the whole image again
    instr_ready = 1'b1;
    start = 1'b1;
    push_range(0, PL - 1);
    tick();
    start = 1'b0;
    wait_halt("halt_restart");
    check("restart_q_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
